serial_subtractor: RTL and testbench

//  - Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
//  - Sequential counterpart of the team's combinational adder cell.
//  - Uses one full-subtractor slice plus a registered borrow, so area stays small for wide operands.
//  - Sits beside the adder datapath. Issued by a controller over a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] d_sr_r;
    logic [WIDTH-1:0] d_sr_next_s;
    logic             borrow_r;
    logic [CNT_W-1:0] cnt_r;
    logic             d_s;
    logic             borrow_next_s;
    logic             last_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
`endif

    // One full-subtractor slice; result packed as {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        full_sub = {(~ai & bi) | (~(ai ^ bi) & bin), ai ^ bi ^ bin};
    endfunction

    // Slice evaluation and next value of the result shift register.
    always_comb begin
        {borrow_next_s, d_s} = full_sub(a_sr_r[0], b_sr_r[0], borrow_r);
        d_sr_next_s          = (d_sr_r >> 1) | (WIDTH'(d_s) << (WIDTH - 1));
        last_s               = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/result shift registers, borrow, bit counter and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r     <= '0;
            b_sr_r     <= '0;
            d_sr_r     <= '0;
            borrow_r   <= 1'b0;
            cnt_r      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r   <= a;
                        b_sr_r   <= b;
                        borrow_r <= 1'b0;
                        cnt_r    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_r  <= a[WIDTH-1];
                        b_msb_r  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    d_sr_r   <= d_sr_next_s;
                    borrow_r <= borrow_next_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        diff       <= d_sr_next_s;
                        borrow_out <= borrow_next_s;
`ifdef SERIAL_SUB_OVF_EN
                        // d_s is the result MSB on the final bit
                        ovf        <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_r == SHIFT);
    assign done = (state_r == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed vectors.
// Define SERIAL_SUB_OVF_EN for both files to also exercise the overflow flag.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level timing (WIDTH busy cycles, one done cycle) and plain arithmetic results
    int           m_remain;
    logic         m_done;
    logic [W-1:0] m_diff, m_pend_diff;
    logic         m_borrow, m_pend_borrow;
    logic         m_ovf, m_pend_ovf;

    always @(posedge clk) begin
        if (rst) begin
            m_remain <= 0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_remain > 0) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
                m_done   <= 1'b1;
                m_diff   <= m_pend_diff;
                m_borrow <= m_pend_borrow;
                m_ovf    <= m_pend_ovf;
            end
        end else if (start) begin
            m_remain      <= W;
            m_pend_diff   <= W'(int'(a) - int'(b));
            m_pend_borrow <= (a < b);
            m_pend_ovf    <= ((int'($signed(a)) - int'($signed(b))) > (2**(W-1) - 1)) ||
                             ((int'($signed(a)) - int'($signed(b))) < -(2**(W-1)));
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_remain != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("diff", 64'(diff), 64'(m_diff));
            chk("borrow_out", 64'(borrow_out), 64'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
        end
    end

    // Wait (bounded) until done is seen at a falling edge; counts busy cycles on the way.
    task automatic wait_done(input string name, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < W + 6 && !seen; i++) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ediff, input logic eborrow);
        int bc;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v;
        wait_done(name, bc);
        chk({name, "_busy_cycles"}, 64'(bc), 64'(W));
        chk({name, "_diff"}, 64'(diff), 64'(ediff));
        chk({name, "_borrow"}, 64'(borrow_out), 64'(eborrow));
        chk({name, "_model_diff"}, 64'(m_diff), 64'(ediff));
    endtask

    initial begin
        int bc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sub_5_3", 8'h05, 8'h03, 8'h02, 1'b0);
        run_op("sub_3_5", 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("sub_5a_5a", 8'h5A, 8'h5A, 8'h00, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
        chk("ovf_80_01", 64'(ovf), 64'd1);
        run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b0);
        chk("ovf_10_01", 64'(ovf), 64'd0);
`endif

        // Start during SHIFT is ignored; a start presented at done is taken on the first IDLE edge
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'h00; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done("inflight", bc);
        chk("inflight_diff", 64'(diff), 64'h02);
        chk("inflight_borrow", 64'(borrow_out), 64'd0);
        start = 1'b1; a = 8'h20; b = 8'h01;
        @(negedge clk);
        chk("thru_idle_busy", 64'(busy), 64'd0);
        chk("thru_idle_done", 64'(done), 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("thru_accept_busy", 64'(busy), 64'd1);
        wait_done("thru", bc);
        chk("thru_diff", 64'(diff), 64'h1F);

        // Reset on the 4th SHIFT cycle abandons the operation
        @(negedge clk);
        start = 1'b1; a = 8'h03; b = 8'h05;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_diff", 64'(diff), 64'd0);
        chk("midrst_borrow", 64'(borrow_out), 64'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        run_op("after_rst", 8'h05, 8'h03, 8'h02, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
